// File: rtl/local_pht_if.sv
// local_pht_if: groups the prediction, update, history-strobe and statistics
// signals of the local pattern history table.
//   pred_pc/pred_hist          -> table   fetch PC and history word
//   pred_index/pred_taken      <- table   index used and prediction
//   upd_valid/index/taken/mispredict -> table   resolved-branch update
//   hist_load/hist_datain      <- table   shift strobe to the history array
//   stat_updates/stat_mispredicts <- table  update statistics
// Modport master is the surrounding pipeline, slave is local_pht.
interface local_pht_if #(
  parameter int hist_width = 8
);
  logic [31:0]           pred_pc;
  logic [hist_width-1:0] pred_hist;
  logic [hist_width-1:0] pred_index;
  logic                  pred_taken;
  logic                  upd_valid;
  logic [hist_width-1:0] upd_index;
  logic                  upd_taken;
  logic                  upd_mispredict;
  logic                  hist_load;
  logic                  hist_datain;
  logic [31:0]           stat_updates;
  logic [31:0]           stat_mispredicts;

  modport master (
    output pred_pc, pred_hist, upd_valid, upd_index, upd_taken, upd_mispredict,
    input  pred_index, pred_taken, hist_load, hist_datain,
    input  stat_updates, stat_mispredicts
  );

  modport slave (
    input  pred_pc, pred_hist, upd_valid, upd_index, upd_taken, upd_mispredict,
    output pred_index, pred_taken, hist_load, hist_datain,
    output stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/local_pht.sv
// local_pht: pattern history table of 2-bit saturating counters for the local
// branch predictor. Prediction is combinational from pred_hist ^ pred_pc.
// Updates go through a two-stage read-modify-write: S1 registers the request,
// S2 reads the counter, saturates it and writes it back on the closing edge,
// while strobing the outcome bit into the upstream history array.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   bus    local_pht_if.slave (prediction, update, history strobe, stats)
// Build option: define PHT_STATS_EN to enable the stat_updates /
// stat_mispredicts counters; otherwise both ports are tied to 0.
module local_pht #(
  parameter int hist_width  = 8,
  parameter int num_entries = 2 ** hist_width
) (
  input logic        clk,
  input logic        reset,
  local_pht_if.slave bus
);

  logic [1:0]            ctr_reg [num_entries];
  logic                  s1_valid_reg;
  logic [hist_width-1:0] s1_index_reg;
  logic                  s1_taken_reg;
  logic                  s1_mispredict_reg;
  logic [1:0]            s1_ctr;
  logic [1:0]            ctr_next;
  logic [hist_width-1:0] cur_index;
  logic                  pc_unused;

  // Only the word-aligned PC bits that overlap the history participate.
  assign cur_index = bus.pred_hist ^ bus.pred_pc[hist_width+1:2];
  assign pc_unused = &{1'b0, bus.pred_pc[31:hist_width+2], bus.pred_pc[1:0], s1_mispredict_reg};

  // S2 read and saturating adjust.
  always_comb begin
    s1_ctr   = ctr_reg[s1_index_reg];
    ctr_next = s1_ctr;
    if (s1_taken_reg) begin
      if (s1_ctr != 2'b11) ctr_next = s1_ctr + 2'b01;
    end else begin
      if (s1_ctr != 2'b00) ctr_next = s1_ctr - 2'b01;
    end
  end

  // A prediction to the index being written this cycle sees the new value.
  always_comb begin
    bus.pred_index = cur_index;
    if (s1_valid_reg && (s1_index_reg == cur_index))
      bus.pred_taken = ctr_next[1];
    else
      bus.pred_taken = ctr_reg[cur_index][1];
  end

  // Gated by reset so an update caught in S1 during reset never strobes.
  assign bus.hist_load   = s1_valid_reg & ~reset;
  assign bus.hist_datain = s1_taken_reg & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg      <= 1'b0;
      s1_index_reg      <= '0;
      s1_taken_reg      <= 1'b0;
      s1_mispredict_reg <= 1'b0;
    end else begin
      // S1 is simply overwritten; the previous request retires on this edge.
      s1_valid_reg <= bus.upd_valid;
      if (bus.upd_valid) begin
        s1_index_reg      <= bus.upd_index;
        s1_taken_reg      <= bus.upd_taken;
        s1_mispredict_reg <= bus.upd_mispredict;
      end
    end
  end

  // One register per counter so the whole table can return to weak
  // not-taken in a single reset cycle.
  genvar gi;
  generate
    for (gi = 0; gi < num_entries; gi++) begin : g_ctr
      always_ff @(posedge clk) begin
        if (reset)
          ctr_reg[gi] <= 2'b01;
        else if (s1_valid_reg && (s1_index_reg == hist_width'(gi)))
          ctr_reg[gi] <= ctr_next;
      end
    end
  endgenerate

`ifdef PHT_STATS_EN
  logic [31:0] stat_updates_reg;
  logic [31:0] stat_mispredicts_reg;

  // Counted at the S1 capture edge; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates_reg     <= '0;
      stat_mispredicts_reg <= '0;
    end else if (bus.upd_valid) begin
      stat_updates_reg <= stat_updates_reg + 32'd1;
      if (bus.upd_mispredict)
        stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign bus.stat_updates     = stat_updates_reg;
  assign bus.stat_mispredicts = stat_mispredicts_reg;
`else
  assign bus.stat_updates     = '0;
  assign bus.stat_mispredicts = '0;
`endif

endmodule

// File: doc/local_pht.md
# local_pht

Pattern history table for the local branch predictor. It sits directly downstream of the per-set branch history shift-register array. Each cycle it combines the history word with the fetch PC to index a table of 2-bit saturating counters and produces a taken/not-taken prediction. On branch resolution it updates the indexed counter through a 2-stage read-modify-write pipeline, and it drives the load/shift-in strobe back to the history array.

## Interface
Parameters:
- hist_width, 8: history word width; must equal the upstream history array width. Also the table index width.
- num_entries, 2**hist_width: counter count (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- pred_pc  in  32  fetch PC of the branch being predicted.
- pred_hist  in  hist_width  history word from the upstream history array.
- pred_index  out  hist_width  table index used for this prediction; carried down the pipe and returned on upd_index.
- pred_taken  out  1  prediction: 1 = taken.
- upd_valid  in  1  resolved-branch update request, one cycle wide.
- upd_index  in  hist_width  pred_index captured at prediction time.
- upd_taken  in  1  actual branch outcome.
- upd_mispredict  in  1  resolved outcome differed from the prediction.
- hist_load  out  1  load strobe to the history array.
- hist_datain  out  1  outcome bit shifted into the history array.
- stat_updates  out  32  count of accepted updates.
- stat_mispredicts  out  32  count of accepted updates with upd_mispredict = 1.

## Operation
- Index is pred_hist XOR pred_pc[hist_width+1:2].
- Counter encoding:
  - 00: strong not-taken.
  - 01: weak not-taken.
  - 10: weak taken.
  - 11: strong taken.
- pred_taken is counter[1].
- Update stage S1: when upd_valid is 1, register upd_index, upd_taken and upd_mispredict, and set s1_valid.
- Update stage S2 (the cycle s1_valid = 1):
  - Read counter[s1_index] and compute next.
  - Taken: next = min(ctr+1, 3). Not taken: next = max(ctr-1, 0). Saturating 2-bit arithmetic, no wrap.
  - Write next at the closing edge.
- Forwarding: if s1_valid = 1 and the current index equals s1_index, pred_taken = next[1], not the stale array value.
- History strobe: hist_load = s1_valid and hist_datain = s1_taken, both combinational from S1 registers. The history array therefore shifts on the same edge the counter is written.
- Back-to-back updates (upd_valid every cycle) are fully supported at one per cycle:
  - Each S2 reads the array after the prior write edge, so consecutive updates to the same index accumulate correctly.
- upd_valid arriving while s1_valid = 1 is accepted; S1 is overwritten on the same edge the previous update retires. There is no stall and no backpressure.
- Reset:
  - All counters become 01.
  - s1_valid = 0, so hist_load = 0 and hist_datain = 0.
  - Statistics counters become 0.
  - After reset, pred_taken = 0 for every index.
  - An update in S1 during reset is discarded: no counter write, no history strobe.
  - upd_valid asserted in the same cycle as reset is ignored.

## Timing
- Prediction: combinational, zero cycles from pred_pc/pred_hist to pred_index/pred_taken.
- Update latency:
  - upd_valid sampled at edge E0.
  - hist_load high during cycle E0→E1.
  - Counter written at E1.
  - A non-forwarded prediction sees the new value from cycle E1→E2. The forwarded value is visible during E0→E1.
- Statistics increment at E0 (the S1 capture edge) and wrap modulo 2^32.

## Configuration
- PHT_STATS_EN defined: stat_updates and stat_mispredicts are live counters as described.
- PHT_STATS_EN undefined: both counters and their logic are removed; the ports remain and are tied to 0.

## Test plan
- Reset, then pred_hist=0x00, pred_pc=0x0000_0000: pred_index=0x00, pred_taken=0; hist_load=0.
- Two updates to index 0x05 with upd_taken=1 on consecutive cycles:
  - hist_load high for 2 cycles with hist_datain=1.
  - Counter 01→10→11; pred_taken=1 at index 0x05.
  - Two further not-taken updates give 11→10→01, pred_taken=0.
- Four taken updates to index 0x3C, then a fifth: counter stays 11 (no wrap to 00). Four not-taken to index 0x11: counter stays 00.
- Forwarding: index 0x22 at 01; upd_valid taken to 0x22 with pred inputs mapping to 0x22 in the following cycle: pred_taken=1 in that same cycle.
- Reset asserted in the cycle s1_valid=1: no counter changes from 01 and hist_load=0. With PHT_STATS_EN, stats read 0 afterward.
- PHT_STATS_EN build: 10 updates, 3 with upd_mispredict=1: stat_updates=10, stat_mispredicts=3. Without the macro, both read 0.
